// File: rtl/mssd_frame_rx.sv
// rtl/mssd_frame_rx.sv - serial frame receiver: start, address, data, optional even parity, stop
module mssd_frame_rx #(
    parameter int CH_W      = 2,
    parameter int DATA_W    = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] p,
    output logic [CH_W-1:0]   d,
    output logic              outva,
    output logic              err
);

    localparam int MAX_W = (CH_W > DATA_W) ? CH_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic              par_bit;
    logic              addr_last;
    logic              data_last;
    logic              parity_ok;
    logic              frame_good;
    logic              frame_bad;

    assign addr_last = (cnt == CNT_W'(CH_W - 1));
    assign data_last = (cnt == CNT_W'(DATA_W - 1));
    assign parity_ok = (PARITY_EN == 0) || ((^data_sr) == par_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!sin) state_nx = S_ADDR;
            S_ADDR:  if (addr_last) state_nx = S_DATA;
            S_DATA:  if (data_last) state_nx = (PARITY_EN != 0) ? S_PAR : S_STOP;
            S_PAR:   state_nx = S_STOP;
            // A low stop bit must not be mistaken for the next start bit.
            S_STOP:  state_nx = sin ? S_IDLE : S_WAIT1;
            S_WAIT1: if (sin) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (state == S_STOP) begin
            frame_good = sin && parity_ok;
            frame_bad  = !(sin && parity_ok);
        end
    end

    // Counter restarts on every state change so each field counts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            addr_sr <= '0;
            data_sr <= '0;
            par_bit <= 1'b0;
        end else begin
            cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
            if (state == S_ADDR) addr_sr <= (addr_sr << 1) | CH_W'(sin);
            if (state == S_DATA) data_sr <= (data_sr << 1) | DATA_W'(sin);
            if (state == S_PAR)  par_bit <= sin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p     <= '0;
            d     <= '0;
            outva <= 1'b0;
            err   <= 1'b0;
        end else begin
            outva <= frame_good;
            err   <= frame_bad;
            if (frame_good) begin
                p <= data_sr;
                d <= addr_sr;
            end
        end
    end

endmodule

// File: tb/tb_mssd_frame_rx.sv
// tb/tb_mssd_frame_rx.sv - frame-level bench for mssd_frame_rx, default and wide configurations
module tb_mssd_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin_a = 1'b1;
    logic       sin_b = 1'b1;
    logic [3:0] p_a;
    logic [1:0] d_a;
    logic       outva_a;
    logic       err_a;
    logic [7:0] p_b;
    logic [2:0] d_b;
    logic       outva_b;
    logic       err_b;

    int vectors = 0;
    int miscompares = 0;
    int mp_a = 0, md_a = 0, mp_b = 0, md_b = 0;

    always #5 clk = ~clk;

    mssd_frame_rx #(.CH_W(2), .DATA_W(4), .PARITY_EN(1)) dut_a (
        .clk(clk), .rst(rst), .sin(sin_a),
        .p(p_a), .d(d_a), .outva(outva_a), .err(err_a)
    );

    mssd_frame_rx #(.CH_W(3), .DATA_W(8), .PARITY_EN(0)) dut_b (
        .clk(clk), .rst(rst), .sin(sin_b),
        .p(p_b), .d(d_b), .outva(outva_b), .err(err_b)
    );

    typedef struct {
        bit sel;
        int ch;
        int data;
        bit flip;
        bit stop;
        int gap;
        bit good;
        int ep;
        int ed;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_cycle(input bit sel, input bit exp_va, input bit exp_er);
        if (sel) begin
            chk("b_outva", 32'(outva_b), 32'(exp_va));
            chk("b_err", 32'(err_b), 32'(exp_er));
            chk("b_p", 32'(p_b), mp_b);
            chk("b_d", 32'(d_b), md_b);
        end else begin
            chk("a_outva", 32'(outva_a), 32'(exp_va));
            chk("a_err", 32'(err_a), 32'(exp_er));
            chk("a_p", 32'(p_a), mp_a);
            chk("a_d", 32'(d_a), md_a);
        end
    endtask

    task automatic drive(input bit sel, input bit b);
        if (sel) sin_b = b;
        else sin_a = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v);
        bit q[$];
        int cw, dw, f;
        bit par;
        cw = v.sel ? 3 : 2;
        dw = v.sel ? 8 : 4;
        q.push_back(1'b0);
        for (int i = cw - 1; i >= 0; i--) q.push_back(bit'((v.ch >> i) & 1));
        par = 1'b0;
        for (int i = dw - 1; i >= 0; i--) begin
            q.push_back(bit'((v.data >> i) & 1));
            par ^= bit'((v.data >> i) & 1);
        end
        if (!v.sel) q.push_back(par ^ v.flip);
        q.push_back(v.stop);
        f = q.size();
        for (int k = 0; k < f; k++) begin
            drive(v.sel, q[k]);
            if (k == f - 1) begin
                if (v.sel) begin mp_b = v.ep; md_b = v.ed; end
                else begin mp_a = v.ep; md_a = v.ed; end
            end
            chk_cycle(v.sel, (k == f - 1) && v.good, (k == f - 1) && !v.good);
        end
        for (int k = 0; k < v.gap; k++) begin
            drive(v.sel, v.stop);
            chk_cycle(v.sel, 1'b0, 1'b0);
        end
        if (!v.stop) begin
            drive(v.sel, 1'b1);
            chk_cycle(v.sel, 1'b0, 1'b0);
        end
        if (v.sel) sin_b = 1'b1;
        else sin_a = 1'b1;
    endtask

    function automatic vec_t rand_vec(input bit sel);
        vec_t v;
        v.sel  = sel;
        v.ch   = sel ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3));
        v.data = sel ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
        v.flip = sel ? 1'b0 : ($urandom_range(0, 3) == 0);
        v.stop = ($urandom_range(0, 4) != 0);
        v.gap  = int'($urandom_range(0, 3));
        v.good = v.stop && !v.flip;
        v.ep   = v.good ? v.data : (sel ? mp_b : mp_a);
        v.ed   = v.good ? v.ch : (sel ? md_b : md_a);
        return v;
    endfunction

    initial begin
        tbl.push_back('{0, 2, 4'b1011, 0, 1, 2, 1, 4'b1011, 2});
        tbl.push_back('{0, 2, 4'b1011, 1, 1, 0, 0, 4'b1011, 2});
        tbl.push_back('{0, 1, 4'b0001, 0, 1, 1, 1, 4'b0001, 1});
        tbl.push_back('{0, 2, 4'b1011, 0, 0, 3, 0, 4'b0001, 1});
        tbl.push_back('{0, 3, 4'b1111, 0, 1, 0, 1, 4'b1111, 3});
        tbl.push_back('{0, 0, 4'b0110, 0, 1, 0, 1, 4'b0110, 0});
        tbl.push_back('{0, 1, 4'b0001, 0, 1, 2, 1, 4'b0001, 1});

        repeat (2) @(posedge clk);
        #1;
        chk_cycle(1'b0, 1'b0, 1'b0);
        chk_cycle(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1);
        chk_cycle(1'b0, 1'b0, 1'b0);

        foreach (tbl[i]) send(tbl[i]);

        for (int i = 0; i < 40; i++) send(rand_vec(1'b0));

        send('{0, 2, 4'b1011, 0, 1, 1, 1, 4'b1011, 2});

        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        sin_a = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        mp_a = 0; md_a = 0; mp_b = 0; md_b = 0;
        chk_cycle(1'b0, 1'b0, 1'b0);
        chk_cycle(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1);
            chk_cycle(1'b0, 1'b0, 1'b0);
        end
        send('{0, 3, 4'b0101, 0, 1, 1, 1, 4'b0101, 3});

        send('{1, 5, 8'hA5, 0, 1, 1, 1, 8'hA5, 5});
        send('{1, 2, 8'h3C, 0, 0, 2, 0, 8'hA5, 5});
        send('{1, 7, 8'h81, 0, 1, 0, 1, 8'h81, 7});
        for (int i = 0; i < 15; i++) send(rand_vec(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mssd_frame_rx.md
# mssd_frame_rx

Parametrised serial frame receiver and demultiplexer, the next generation of the fixed-width MSSD serial stream decoder. It samples a single-bit serial line, detects a start bit, and shifts in a channel address and a data word of configurable width. It checks an optional even-parity bit and a stop bit, then presents the word and address in parallel with a one-cycle valid strobe. Framing and parity faults raise a one-cycle error strobe. The block sits between the serial link pin and the per-channel consumers.

## Interface
- CH_W, 2, channel address width in bits (d width); 1..4
- DATA_W, 4, data word width in bits (p width); 1..16
- PARITY_EN, 1, 1: frame carries even-parity bit after data; 0: no parity bit
- clk  input  1  clock; all sampling on rising edge
- rst  input  1  reset, asynchronous, active-high
- sin  input  1  serial line; idles high
- p  output  DATA_W  last good data word
- d  output  CH_W  channel address of last good frame
- outva  output  1  one-cycle strobe: good frame delivered on p/d
- err  output  1  one-cycle strobe: frame rejected (parity or stop error)

## Operation
- Frame, MSB first, one bit per clock: start(0), CH_W address bits, DATA_W data bits, parity bit if PARITY_EN, stop(1). Frame length F = CH_W + DATA_W + PARITY_EN + 2 bits.
- States:
  - IDLE: sin=0 -> ADDR with bit counter cleared; sin=1 stays.
  - ADDR: shift sin into the address shift register for CH_W cycles -> DATA.
  - DATA: shift sin into the data shift register for DATA_W cycles -> PAR if PARITY_EN, else STOP.
  - PAR: latch sin as received parity -> STOP.
  - STOP: sample sin, then check and decide (see below).
  - WAIT1: wait for sin=1 -> IDLE.
- Parity is even over the data bits only: XOR of the data bits XOR the parity bit must be 0. The address is not covered.
- STOP decision:
  - Good (sin=1, parity ok or PARITY_EN=0): load p and d from the shift registers, pulse outva -> IDLE.
  - Bad parity with stop=1: pulse err; p and d unchanged -> IDLE.
  - Stop bit = 0 (framing error, any parity): pulse err; p and d unchanged -> WAIT1. A 0 stop bit is never treated as a new start.
- Back-to-back frames are legal: a start bit sampled on the edge immediately after the stop bit is accepted.
- outva and err are mutually exclusive; each is high for at most one cycle per frame.
- Reset mid-frame: the partial frame is discarded and no strobe is issued. After release the block is in IDLE.

## Timing
- Reset values: p=0, d=0, outva=0, err=0, state IDLE, counter 0, shift registers 0.
- Every sin sample is taken at a rising clk edge. The start bit is edge 0; the stop bit is sampled at edge F-1.
- outva or err rises at edge F-1 (the stop-sampling edge) and falls at edge F. p and d change at edge F-1 and hold until the next good frame.
- The bit counter is wide enough for max(CH_W, DATA_W). Its wrap-around is never visible; it clears on each state entry.
- Latency from start-bit edge to outva is F-1 clocks.
- Default parameters give F=9, so outva arrives 8 clocks after the start edge.

## Test plan
All scenarios use default parameters.
- Good frame: sin = 0,1,0,1,0,1,1,1,1 (ch=2, data=1011, parity=1, stop=1) -> outva pulses one cycle at edge 8; p=4'b1011, d=2'b10; err stays 0.
- Parity error: same frame with parity bit 0 -> err pulses at edge 8; outva=0; p and d keep their previous values. The next frame is accepted normally.
- Framing error: good frame with stop=0, then sin held 0 for 3 cycles, then 1 -> err pulses once and no spurious start occurs. A following good frame 0,0,1,0,0,0,1,1,1 (ch=1, data=0001, parity=1) yields outva with p=1, d=1.
- Back-to-back: two good frames with no idle gap (ch=3 data=1111 par=0, then ch=0 data=0110 par=0) -> outva at edges 8 and 17; p/d = 1111/11, then 0110/00.
- Reset mid-frame: assert rst asynchronously (between edges) at bit 5 of a frame, release, then send a good frame -> no strobe for the aborted frame; outputs are 0 during reset; the new frame delivers correctly.
- Parameter sweep: CH_W=3, DATA_W=8, PARITY_EN=0 -> F=13, outva at edge 12. Data 8'hA5 on ch 5 gives p=8'hA5, d=3'd5.
